// File: rtl/receiver.sv
// Ethernet MAC RX receiver: it parses the 14-byte header and filters on the destination address.
// Accepted payload bytes go into a show-ahead FIFO, and frame done/error events are reported as pulses.
module receiver #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [47:0] OWN_ADDR   = 48'h3F3F_3F3F_3F3F,
  parameter bit          FILTER_EN  = 1'b1,
  parameter int unsigned MAX_LEN    = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_axis_tdata,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic [47:0] header_dst,
  output logic [47:0] header_src,
  output logic [15:0] number_of_bytes,
  output logic        rx_header_valid,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        brx_full,
  output logic        rx_frame_done,
  output logic        rx_frame_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [CW-1:0] DEPTH_W   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, DST, SRC, LEN, PAYLOAD, PAD, DROP} state_t;

  state_t          state, state_n;
  logic            first_cyc;
  logic [3:0]      hdr_cnt, hdr_inc;
  logic [47:0]     dst_sr, src_sr;
  logic [7:0]      len_hi;
  logic [15:0]     len_full, remaining;
  logic            unbounded, ovf;
  logic            beat, addr_ok;
  logic            hdr_take, push, push_ok, pop, full, ovf_now, runt, err_n, done_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;

  assign beat     = rx_axis_tvalid;
  assign len_full = {len_hi, rx_axis_tdata};
  assign addr_ok  = !FILTER_EN || (dst_sr == OWN_ADDR) || (dst_sr == '1);
  assign rx_data  = mem[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state; tlast always returns to IDLE so a new frame can start on the next beat
  always_comb begin
    state_n = state;
    if (beat) begin
      if (rx_axis_tlast) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE:    state_n = first_cyc ? DROP : DST;
          DST:     if (hdr_cnt == 4'd5)  state_n = SRC;
          SRC:     if (hdr_cnt == 4'd11) state_n = LEN;
          LEN: begin
            if (hdr_cnt == 4'd13) begin
              if (!addr_ok)                     state_n = DROP;
              else if (len_full == 16'd0)       state_n = PAD;
              else                              state_n = PAYLOAD;
            end
          end
          PAYLOAD: if (!unbounded && remaining == 16'd1) state_n = PAD;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle controls: header capture, FIFO push/pop, end-of-frame classification
  always_comb begin
    hdr_take = 1'b0;
    push     = 1'b0;
    runt     = 1'b0;
    hdr_inc  = (hdr_cnt == 4'hF) ? hdr_cnt : hdr_cnt + 4'd1;
    if (beat) begin
      case (state)
        IDLE:     runt = !first_cyc;
        DST, SRC: runt = 1'b1;
        LEN: begin
          runt     = 1'b1;
          hdr_take = (hdr_cnt == 4'd13) && addr_ok;
        end
        PAYLOAD: begin
          push = 1'b1;
          runt = !unbounded && (remaining != 16'd1);
        end
        default: ;
      endcase
    end
    pop     = rx_valid && rx_ready;
    full    = (count == DEPTH_W);
    push_ok = push && (!full || pop);
    ovf_now = push && full && !pop;
    err_n   = beat && rx_axis_tlast && (runt || rx_axis_tuser || ovf || ovf_now);
    done_n  = beat && rx_axis_tlast && !err_n && (state == PAYLOAD || state == PAD);
    count_n = count;
    if (push_ok && !pop)      count_n = count + CW'(1);
    else if (!push_ok && pop) count_n = count - CW'(1);
  end

  // Header shift registers, payload counter and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_cyc       <= 1'b1;
      hdr_cnt         <= '0;
      dst_sr          <= '0;
      src_sr          <= '0;
      len_hi          <= '0;
      remaining       <= '0;
      unbounded       <= 1'b0;
      ovf             <= 1'b0;
      header_dst      <= '0;
      header_src      <= '0;
      number_of_bytes <= '0;
      rx_header_valid <= 1'b0;
      rx_frame_done   <= 1'b0;
      rx_frame_err    <= 1'b0;
    end else begin
      first_cyc       <= 1'b0;
      rx_header_valid <= hdr_take;
      rx_frame_done   <= done_n;
      rx_frame_err    <= err_n;
      if (hdr_take) begin
        header_dst      <= dst_sr;
        header_src      <= src_sr;
        number_of_bytes <= len_full;
      end
      if (beat && state == IDLE) ovf <= 1'b0;
      else if (ovf_now)          ovf <= 1'b1;
      if (beat) begin
        case (state)
          IDLE: begin
            dst_sr  <= {dst_sr[39:0], rx_axis_tdata};
            hdr_cnt <= 4'd1;
          end
          DST: begin
            dst_sr  <= {dst_sr[39:0], rx_axis_tdata};
            hdr_cnt <= hdr_inc;
          end
          SRC: begin
            src_sr  <= {src_sr[39:0], rx_axis_tdata};
            hdr_cnt <= hdr_inc;
          end
          LEN: begin
            hdr_cnt <= hdr_inc;
            if (hdr_cnt == 4'd12) len_hi <= rx_axis_tdata;
            if (hdr_cnt == 4'd13) begin
              remaining <= len_full;
              unbounded <= (len_full > MAX_LEN_W);
            end
          end
          PAYLOAD: if (remaining != 16'd0) remaining <= remaining - 16'd1;
          default: ;
        endcase
      end
    end
  end

  // Payload FIFO; a push into a full FIFO lands only when a pop frees the slot in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_valid <= 1'b0;
      brx_full <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[AW'(i)] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_axis_tdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_n;
      rx_valid <= (count_n != '0);
      brx_full <= (count_n == DEPTH_W);
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed frames plus randomized frames against a frame-level model.
module tb_receiver;

  localparam logic [47:0] OWN   = 48'h3F3F_3F3F_3F3F;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n, tvalid, tlast, tuser, rx_ready;
  logic [7:0]  tdata;
  logic [47:0] a_dst, a_src, b_dst, b_src;
  logic [15:0] a_nob, b_nob;
  logic [7:0]  a_data, b_data;
  logic        a_hv, a_valid, a_full, a_done, a_err;
  logic        b_hv, b_valid, b_full, b_done, b_err;

  int checks = 0, failures = 0;
  int ready_mode = 0;
  int exp_hdr = 0, exp_done = 0, exp_err = 0, seen_hdr = 0, seen_done = 0, seen_err = 0;
  int b_hdr = 0, b_dn = 0, b_er = 0, b_pops = 0;
  bit b_check = 1'b0;
  logic [7:0]   frm[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   exp_qb[$];
  logic [111:0] exp_hq[$];

  receiver dut_a (
    .clk(clk), .rst_n(rst_n), .rx_axis_tdata(tdata), .rx_axis_tvalid(tvalid),
    .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .header_dst(a_dst), .header_src(a_src),
    .number_of_bytes(a_nob), .rx_header_valid(a_hv), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(rx_ready), .brx_full(a_full), .rx_frame_done(a_done), .rx_frame_err(a_err)
  );

  receiver #(.FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_axis_tdata(tdata), .rx_axis_tvalid(tvalid),
    .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .header_dst(b_dst), .header_src(b_src),
    .number_of_bytes(b_nob), .rx_header_valid(b_hv), .rx_data(b_data), .rx_valid(b_valid),
    .rx_ready(rx_ready), .brx_full(b_full), .rx_frame_done(b_done), .rx_frame_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle: header pulses against the expected header queue, pops against the payload queue
  task automatic monitor();
    logic [111:0] h;
    if (a_hv) begin
      seen_hdr++;
      if (exp_hq.size() == 0) chk("hdr_unexpected", 64'(exp_hq.size()), 64'(1));
      else begin
        h = exp_hq.pop_front();
        chk("header_dst", 64'(a_dst), 64'(h[111:64]));
        chk("header_src", 64'(a_src), 64'(h[63:16]));
        chk("number_of_bytes", 64'(a_nob), 64'(h[15:0]));
      end
    end
    if (a_done) seen_done++;
    if (a_err)  seen_err++;
    if (a_valid && rx_ready) begin
      if (exp_q.size() == 0) chk("pop_extra", 64'(exp_q.size()), 64'(1));
      else chk("rx_data", 64'(a_data), 64'(exp_q.pop_front()));
    end
    if (b_hv)   b_hdr++;
    if (b_done) b_dn++;
    if (b_err)  b_er++;
    if (b_valid && rx_ready) begin
      b_pops++;
      if (b_check) begin
        if (exp_qb.size() == 0) chk("b_pop_extra", 64'(exp_qb.size()), 64'(1));
        else chk("b_rx_data", 64'(b_data), 64'(exp_qb.pop_front()));
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic u);
    @(posedge clk);
    #1;
    tvalid = v; tdata = d; tlast = l; tuser = u;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic make_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] l);
    logic [111:0] h;
    h = {d, s, l};
    frm.delete();
    for (int i = 13; i >= 0; i--) frm.push_back(h[i*8 +: 8]);
  endtask

  task automatic send_frame(input bit u);
    for (int i = 0; i < frm.size(); i++)
      drive(1'b1, frm[i], i == frm.size() - 1, (i == frm.size() - 1) && u);
  endtask

  // Frame-level reference: what the consumer should see for the bytes in frm
  task automatic model_frame(input bit u);
    int n, avail, take;
    logic [47:0] d, s;
    logic [15:0] l;
    n = frm.size();
    d = '0; s = '0; l = '0;
    for (int i = 0; i < 6 && i < n; i++)  d = {d[39:0], frm[i]};
    for (int i = 6; i < 12 && i < n; i++) s = {s[39:0], frm[i]};
    if (n >= 14) l = {frm[12], frm[13]};
    if (n < 14) begin exp_err++; return; end
    if (d != OWN && d != BCAST) begin
      if (u || n == 14) exp_err++;
      return;
    end
    exp_hq.push_back({d, s, l});
    exp_hdr++;
    if (n == 14) begin exp_err++; return; end
    avail = n - 14;
    if (int'(l) <= 1500) begin
      take = (avail < int'(l)) ? avail : int'(l);
      for (int i = 0; i < take; i++) exp_q.push_back(frm[14 + i]);
      if (avail < int'(l) || u) exp_err++; else exp_done++;
    end else begin
      for (int i = 0; i < avail; i++) exp_q.push_back(frm[14 + i]);
      if (u) exp_err++; else exp_done++;
    end
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || a_valid); k++) idle(1);
    idle(3);
    chk("drain_queue_left", 64'(exp_q.size()), 64'(0));
    chk("drain_rx_valid", 64'(a_valid), 64'(0));
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_hdr_pulses"}, 64'(seen_hdr), 64'(exp_hdr));
    chk({tag, "_done_pulses"}, 64'(seen_done), 64'(exp_done));
    chk({tag, "_err_pulses"}, 64'(seen_err), 64'(exp_err));
    chk({tag, "_hdr_left"}, 64'(exp_hq.size()), 64'(0));
  endtask

  initial begin
    int bh, bd, be, bp, sel, avail;
    logic [63:0] r;
    logic [47:0] d;
    logic [15:0] l;
    bit u;

    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tuser = 1'b0; rx_ready = 1'b0;
    idle(3);
    chk("rst_rx_valid", 64'(a_valid), 64'(0));
    chk("rst_brx_full", 64'(a_full), 64'(0));
    chk("rst_header_dst", 64'(a_dst), 64'(0));
    chk("rst_header_src", 64'(a_src), 64'(0));
    chk("rst_nob", 64'(a_nob), 64'(0));
    chk("rst_pulses", 64'({a_hv, a_done, a_err}), 64'(0));
    chk("rst_rx_data", 64'(a_data), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Basic 3-byte payload frame
    ready_mode = 1;
    make_hdr(OWN, 48'h1112_1314_1516, 16'h0003);
    frm.push_back(8'hCC); frm.push_back(8'hDD); frm.push_back(8'hEE);
    model_frame(1'b0);
    send_frame(1'b0);
    drain();
    check_counts("basic");
    chk("basic_hold_dst", 64'(a_dst), 64'(OWN));
    chk("basic_hold_nob", 64'(a_nob), 64'(16'h0003));

    // Length 2 with 44 padding bytes
    make_hdr(OWN, 48'h1112_1314_1516, 16'h0002);
    frm.push_back(8'hAA); frm.push_back(8'hBB);
    for (int i = 0; i < 44; i++) frm.push_back(8'h00);
    model_frame(1'b0);
    send_frame(1'b0);
    drain();
    check_counts("pad");

    // Filtered destination, then a back-to-back accepted frame
    make_hdr(48'h0200_0000_0001, 48'h2122_2324_2526, 16'h0003);
    frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
    model_frame(1'b0);
    send_frame(1'b0);
    chk("filtered_fifo_empty", 64'(a_valid), 64'(0));
    make_hdr(BCAST, 48'h3132_3334_3536, 16'h0004);
    for (int i = 0; i < 4; i++) frm.push_back(8'(8'h70 + i));
    model_frame(1'b0);
    send_frame(1'b0);
    drain();
    check_counts("filter");

    // Runt: tlast on the 10th byte, then a normal frame
    make_hdr(OWN, 48'h4142_4344_4546, 16'h0005);
    while (frm.size() > 10) void'(frm.pop_back());
    model_frame(1'b0);
    send_frame(1'b0);
    idle(2);
    make_hdr(OWN, 48'h5152_5354_5556, 16'h0002);
    frm.push_back(8'h9A); frm.push_back(8'h9B);
    model_frame(1'b0);
    send_frame(1'b0);
    drain();
    check_counts("runt");

    // Overflow on the 4-entry instance with an EtherType frame
    ready_mode = 0;
    bh = b_hdr; bd = b_dn; be = b_er;
    make_hdr(OWN, 48'h1112_1314_1516, 16'h0800);
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'h51 + i));
    model_frame(1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, frm[i], i == frm.size() - 1, 1'b0);
      if (i == 17) chk("b_full_after3", 64'(b_full), 64'(0));
      if (i == 18) chk("b_full_after4", 64'(b_full), 64'(1));
    end
    idle(3);
    chk("b_full_held", 64'(b_full), 64'(1));
    chk("a_not_full", 64'(a_full), 64'(0));
    chk("b_hdr_pulse", 64'(b_hdr - bh), 64'(1));
    chk("b_err_pulse", 64'(b_er - be), 64'(1));
    chk("b_no_done", 64'(b_dn - bd), 64'(0));
    for (int i = 0; i < 4; i++) exp_qb.push_back(8'(8'h51 + i));
    b_check = 1'b1;
    bp = b_pops;
    drain();
    b_check = 1'b0;
    chk("b_drain_count", 64'(b_pops - bp), 64'(4));
    chk("b_drain_left", 64'(exp_qb.size()), 64'(0));
    chk("b_drain_valid", 64'(b_valid), 64'(0));
    check_counts("ovf");

    // One-cycle reset mid-payload with tvalid held high
    ready_mode = 0;
    make_hdr(OWN, 48'h6162_6364_6566, 16'd20);
    for (int i = 0; i < 20; i++) frm.push_back(8'(8'hC0 + i));
    exp_hq.push_back({OWN, 48'h6162_6364_6566, 16'd20});
    exp_hdr++;
    for (int i = 0; i < 20; i++) drive(1'b1, frm[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, frm[20], 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(a_valid), 64'(0));
    chk("mid_rst_full", 64'(a_full), 64'(0));
    chk("mid_rst_dst", 64'(a_dst), 64'(0));
    chk("mid_rst_src", 64'(a_src), 64'(0));
    chk("mid_rst_nob", 64'(a_nob), 64'(0));
    chk("mid_rst_data", 64'(a_data), 64'(0));
    chk("mid_rst_b_valid", 64'(b_valid), 64'(0));
    for (int i = 21; i < frm.size(); i++) drive(1'b1, frm[i], i == frm.size() - 1, 1'b0);
    drain();
    check_counts("midrst");
    make_hdr(OWN, 48'h7172_7374_7576, 16'h0003);
    frm.push_back(8'h0A); frm.push_back(8'h0B); frm.push_back(8'h0C);
    model_frame(1'b0);
    send_frame(1'b0);
    drain();
    check_counts("postrst");

    // Randomized frames with random consumer readiness
    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(0, 3);
      r = {$urandom(), $urandom()};
      d = (sel < 2) ? OWN : (sel == 2) ? BCAST : {8'h02, r[39:0]};
      if ($urandom_range(0, 1) == 1) begin
        l = 16'($urandom_range(0, 40));
        avail = int'(l) + $urandom_range(0, 12) - 3;
        if (avail < 1) avail = 1;
      end else begin
        l = ($urandom_range(0, 1) == 1) ? 16'h0800 : 16'($urandom_range(1501, 65535));
        avail = $urandom_range(1, 40);
      end
      r = {$urandom(), $urandom()};
      make_hdr(d, r[47:0], l);
      for (int i = 0; i < avail; i++) frm.push_back(8'($urandom_range(0, 255)));
      u = ($urandom_range(0, 7) == 0);
      model_frame(u);
      ready_mode = 2;
      idle($urandom_range(0, 3));
      send_frame(u);
      drain();
    end
    check_counts("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
